// File: rtl/clint.sv
// Core-local interruptor: 64-bit mtime/mtimecmp timer and msip software
// interrupt behind a single-cycle-response memory slave port.
module clint #(
   parameter int unsigned RTC_DIV      = 1,
   parameter logic [15:0] OFF_MSIP     = 16'h0000,
   parameter logic [15:0] OFF_MTIMECMP = 16'h4000,
   parameter logic [15:0] OFF_MTIME    = 16'hBFF8
) (
   input  logic        rst,
   input  logic        clk,
   input  logic        memory_valid,
   input  logic        memory_instr,
   input  logic [31:0] memory_addr,
   input  logic [31:0] memory_wdata,
   input  logic [3:0]  memory_wstrb,
   output logic [31:0] memory_rdata,
   output logic        memory_ready,
   output logic        timer_irpt,
   output logic        soft_irpt
);

   typedef enum logic {IDLE, RESP} state_t;

   localparam logic [15:0] DIV_M1    = 16'(RTC_DIV - 1);
   localparam logic [13:0] W_MSIP    = OFF_MSIP[15:2];
   localparam logic [13:0] W_CMP_LO  = OFF_MTIMECMP[15:2];
   localparam logic [13:0] W_CMP_HI  = OFF_MTIMECMP[15:2] + 14'd1;
   localparam logic [13:0] W_TIME_LO = OFF_MTIME[15:2];
   localparam logic [13:0] W_TIME_HI = OFF_MTIME[15:2] + 14'd1;

   state_t      state;
   logic [15:0] presc;
   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic        msip;

   logic        tick;
   logic        wr;
   logic [13:0] woff;
   logic [31:0] wmask;
   logic [31:0] rd;
   logic        sel_msip, sel_cmp_lo, sel_cmp_hi;
   logic        sel_time_lo, sel_time_hi;

   wire unused = ^{memory_instr, memory_addr[31:16], memory_addr[1:0]};

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] val,
                                         input logic [31:0] mask);
      return (old & ~mask) | (val & mask);
   endfunction

   always_comb begin
      woff        = memory_addr[15:2];
      tick        = (presc == DIV_M1);
      wr          = (state == IDLE) && memory_valid && (|memory_wstrb);
      wmask       = {{8{memory_wstrb[3]}}, {8{memory_wstrb[2]}},
                     {8{memory_wstrb[1]}}, {8{memory_wstrb[0]}}};
      sel_msip    = (woff == W_MSIP);
      sel_cmp_lo  = (woff == W_CMP_LO);
      sel_cmp_hi  = (woff == W_CMP_HI);
      sel_time_lo = (woff == W_TIME_LO);
      sel_time_hi = (woff == W_TIME_HI);
      rd          = 32'h0;
      case (1'b1)
         sel_msip:    rd = {31'h0, msip};
         sel_cmp_lo:  rd = mtimecmp[31:0];
         sel_cmp_hi:  rd = mtimecmp[63:32];
         sel_time_lo: rd = mtime[31:0];
         sel_time_hi: rd = mtime[63:32];
         default:     rd = 32'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         presc        <= '0;
         mtime        <= '0;
         mtimecmp     <= '1;
         msip         <= 1'b0;
         memory_ready <= 1'b0;
         memory_rdata <= '0;
         timer_irpt   <= 1'b0;
         soft_irpt    <= 1'b0;
      end else begin
         presc      <= tick ? '0 : presc + 16'd1;
         timer_irpt <= (mtime >= mtimecmp);
         soft_irpt  <= msip;

         // A write to either mtime half suppresses that cycle's increment.
         if (wr && sel_time_lo)
            mtime <= {mtime[63:32], merge(mtime[31:0], memory_wdata, wmask)};
         else if (wr && sel_time_hi)
            mtime <= {merge(mtime[63:32], memory_wdata, wmask), mtime[31:0]};
         else if (tick)
            mtime <= mtime + 64'd1;

         if (wr && sel_cmp_lo)
            mtimecmp[31:0] <= merge(mtimecmp[31:0], memory_wdata, wmask);
         if (wr && sel_cmp_hi)
            mtimecmp[63:32] <= merge(mtimecmp[63:32], memory_wdata, wmask);
         if (wr && sel_msip && memory_wstrb[0])
            msip <= memory_wdata[0];

         case (state)
            IDLE: begin
               if (memory_valid) begin
                  state        <= RESP;
                  memory_ready <= 1'b1;
                  memory_rdata <= rd;
               end
            end
            RESP: begin
               state        <= IDLE;
               memory_ready <= 1'b0;
            end
            default: begin
               state        <= IDLE;
               memory_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clint.sv
// Bench for clint: two instances (RTC_DIV 1 and 4) share one bus and are
// checked every cycle against a register-level model, plus directed cases.
module tb_clint;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0;
   logic        instr = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;

   logic [31:0] rd0, rd1;
   logic        rdy0, rdy1, tmr0, tmr1, sft0, sft1;

   int checks = 0;
   int errors = 0;

   localparam int unsigned DIVS [2] = '{1, 4};

   always #5 clk = ~clk;

   clint #(.RTC_DIV(1)) dut1 (
      .rst(rst), .clk(clk), .memory_valid(valid), .memory_instr(instr),
      .memory_addr(addr), .memory_wdata(wdata), .memory_wstrb(wstrb),
      .memory_rdata(rd0), .memory_ready(rdy0),
      .timer_irpt(tmr0), .soft_irpt(sft0)
   );

   clint #(.RTC_DIV(4)) dut4 (
      .rst(rst), .clk(clk), .memory_valid(valid), .memory_instr(instr),
      .memory_addr(addr), .memory_wdata(wdata), .memory_wstrb(wstrb),
      .memory_rdata(rd1), .memory_ready(rdy1),
      .timer_irpt(tmr1), .soft_irpt(sft1)
   );

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                              input logic [31:0] val,
                                              input logic [3:0] st);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (st[b]) r[8*b +: 8] = val[8*b +: 8];
      return r;
   endfunction

   // Model: the architectural registers, the cycle count since reset and
   // the outputs the block must show after each edge.
   logic [63:0] m_time [2];
   logic [63:0] m_cmp [2];
   logic        m_msip [2];
   int unsigned m_cyc [2];
   logic        e_ready [2];
   logic [31:0] e_rdata [2];
   logic        e_timer [2];
   logic        e_soft [2];
   logic [63:0] nt;
   logic [31:0] rv;
   logic [13:0] w;
   bit          tk;

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_time[k]  = '0;
            m_cmp[k]   = '1;
            m_msip[k]  = 1'b0;
            m_cyc[k]   = 0;
            e_ready[k] = 1'b0;
            e_rdata[k] = '0;
            e_timer[k] = 1'b0;
            e_soft[k]  = 1'b0;
         end else begin
            tk = (m_cyc[k] % DIVS[k]) == DIVS[k] - 1;
            m_cyc[k]++;
            e_timer[k] = m_time[k] >= m_cmp[k];
            e_soft[k]  = m_msip[k];
            nt = tk ? m_time[k] + 64'd1 : m_time[k];
            if (!e_ready[k] && valid) begin
               e_ready[k] = 1'b1;
               w = addr[15:2];
               case (w)
                  14'h0000: rv = {31'h0, m_msip[k]};
                  14'h1000: rv = m_cmp[k][31:0];
                  14'h1001: rv = m_cmp[k][63:32];
                  14'h2FFE: rv = m_time[k][31:0];
                  14'h2FFF: rv = m_time[k][63:32];
                  default:  rv = 32'h0;
               endcase
               e_rdata[k] = rv;
               if (wstrb != 4'h0) begin
                  case (w)
                     14'h0000: if (wstrb[0]) m_msip[k] = wdata[0];
                     14'h1000: m_cmp[k][31:0] =
                        lane_merge(m_cmp[k][31:0], wdata, wstrb);
                     14'h1001: m_cmp[k][63:32] =
                        lane_merge(m_cmp[k][63:32], wdata, wstrb);
                     14'h2FFE: nt = {m_time[k][63:32],
                        lane_merge(m_time[k][31:0], wdata, wstrb)};
                     14'h2FFF: nt = {lane_merge(m_time[k][63:32], wdata,
                        wstrb), m_time[k][31:0]};
                     default: ;
                  endcase
               end
            end else begin
               e_ready[k] = 1'b0;
            end
            m_time[k] = nt;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         check("ready[div1]", rdy0, e_ready[0]);
         check("ready[div4]", rdy1, e_ready[1]);
         check("timer[div1]", tmr0, e_timer[0]);
         check("timer[div4]", tmr1, e_timer[1]);
         check("soft[div1]", sft0, e_soft[0]);
         check("soft[div4]", sft1, e_soft[1]);
         if (e_ready[0]) check("rdata[div1]", rd0, e_rdata[0]);
         if (e_ready[1]) check("rdata[div4]", rd1, e_rdata[1]);
      end
   end

   task automatic bus(input logic [15:0] off, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] r0,
                      output logic [31:0] r1);
      @(negedge clk);
      valid = 1'b1;
      addr  = {16'h0, off};
      wdata = wd;
      wstrb = st;
      @(negedge clk);
      check("bus ready div1", rdy0, 1'b1);
      check("bus ready div4", rdy1, 1'b1);
      r0    = rd0;
      r1    = rd1;
      valid = 1'b0;
      wstrb = 4'h0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   logic [31:0] a0, a1, b0, b1;
   logic [31:0] ra, wd;
   logic [15:0] off;
   logic [3:0]  st;
   bit          found;

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset timer", tmr0, 1'b0);
      check("reset soft", sft0, 1'b0);
      check("reset ready", rdy0, 1'b0);

      bus(16'hBFF8, 32'h0, 4'h0, a0, a1);
      bus(16'hBFF8, 32'h0, 4'h0, b0, b1);
      check("mtime lo +2", b0 - a0, 32'd2);

      bus(16'h0000, 32'h1, 4'hF, a0, a1);
      check("soft before lag", sft0, 1'b0);
      @(negedge clk);
      check("ready one cycle", rdy0, 1'b0);
      check("soft set", sft0, 1'b1);
      bus(16'h0000, 32'h0, 4'h0, a0, a1);
      check("msip read 1", a0, 32'h1);
      bus(16'h0000, 32'h0, 4'hF, a0, a1);
      @(negedge clk);
      check("soft clear", sft0, 1'b0);
      bus(16'h0000, 32'h0, 4'h0, a0, a1);
      check("msip read 0", a0, 32'h0);

      pulse_reset();
      bus(16'h4004, 32'h0, 4'hF, a0, a1);
      bus(16'h4000, 32'd20, 4'hF, a0, a1);
      found = 1'b0;
      for (int n = 0; n < 100; n++) begin
         if (tmr0) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("timer rise seen", found, 1'b1);
      bus(16'hBFF8, 32'h0, 4'h0, a0, a1);
      check("mtime at timer rise", a0, 32'd22);
      bus(16'h4000, 32'd1000, 4'hF, a0, a1);
      check("timer still set", tmr0, 1'b1);
      @(negedge clk);
      check("timer cleared", tmr0, 1'b0);

      bus(16'hBFF8, 32'h0, 4'h0, a0, a1);
      repeat (38) @(negedge clk);
      bus(16'hBFF8, 32'h0, 4'h0, b0, b1);
      check("div4 40 cycles", b1 - a1, 32'd10);

      bus(16'hBFFC, 32'hFFFF_FFFF, 4'hF, a0, a1);
      bus(16'hBFF8, 32'hFFFF_FFFE, 4'hF, a0, a1);
      bus(16'hBFF8, 32'h0, 4'h0, a0, a1);
      check("pre-wrap lo", a0, 32'hFFFF_FFFF);
      bus(16'hBFFC, 32'h0, 4'h0, a0, a1);
      check("wrapped hi", a0, 32'h0);
      bus(16'hBFF8, 32'h0, 4'h0, a0, a1);
      check("wrapped lo", a0, 32'd3);
      bus(16'hBFF8, 32'd100, 4'hF, a0, a1);
      bus(16'hBFF8, 32'h0, 4'h0, a0, a1);
      check("write beats tick", a0, 32'd101);

      pulse_reset();
      bus(16'h4000, 32'hAABB_CCDD, 4'b0101, a0, a1);
      bus(16'h4000, 32'h0, 4'h0, a0, a1);
      check("byte lanes", a0, 32'hFFBB_FFDD);
      bus(16'h1000, 32'h0, 4'h0, a0, a1);
      check("unmapped read", a0, 32'h0);

      @(negedge clk);
      valid = 1'b1;
      addr  = 32'h0;
      wdata = 32'h1;
      wstrb = 4'hF;
      @(negedge clk);
      check("resp before rst", rdy0, 1'b1);
      rst   = 1'b1;
      valid = 1'b0;
      wstrb = 4'h0;
      @(negedge clk);
      check("rst in resp ready", rdy0, 1'b0);
      check("rst in resp soft", sft0, 1'b0);
      valid = 1'b1;
      wstrb = 4'hF;
      @(negedge clk);
      check("rst drops request", rdy0, 1'b0);
      rst   = 1'b0;
      valid = 1'b0;
      wstrb = 4'h0;
      bus(16'h0000, 32'h0, 4'h0, a0, a1);
      check("msip after rst", a0, 32'h0);

      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 5))
            0: off = 16'h0000;
            1: off = 16'h4000;
            2: off = 16'h4004;
            3: off = 16'hBFF8;
            4: off = 16'hBFFC;
            default: off = 16'($urandom) & 16'hFFFC;
         endcase
         wd = $urandom;
         if ($urandom_range(0, 1) == 1) wd = $urandom_range(0, 60);
         st = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
         ra = $urandom;
         instr = ra[0];
         @(negedge clk);
         valid = 1'b1;
         addr  = {ra[31:16], off[15:2], ra[1:0]};
         wdata = wd;
         wstrb = st;
         @(negedge clk);
         valid = 1'b0;
         wstrb = 4'h0;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         if ($urandom_range(0, 60) == 0) pulse_reset();
      end

      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
